// File: rtl/psum_drain_collector.sv
// Drain collector for the bottom row of the systolic array: deskews the column
// streams, requantizes each aligned row vector and queues it behind a valid/ready port.
module psum_drain_collector #(
    parameter int NUM_COLS    = 4,
    parameter int ACCUM_WIDTH = 24,
    parameter int OUT_WIDTH   = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            ext_enable,
    output logic                            array_enable,
    input  logic [NUM_COLS*ACCUM_WIDTH-1:0] col_psum_in,
    input  logic [NUM_COLS-1:0]             col_valid_in,
    input  logic [4:0]                      shift_amt,
    input  logic                            relu_en,
    input  logic [CNT_WIDTH-1:0]            rows_expected,
    output logic [NUM_COLS*OUT_WIDTH-1:0]   out_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic                            frame_done,
    output logic                            skew_error
);

    localparam int AW    = ACCUM_WIDTH;
    localparam int OW    = OUT_WIDTH;
    localparam int VW    = NUM_COLS * OUT_WIDTH;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic signed [AW:0] SAT_MAX = (AW+1)'((2 ** (OW - 1)) - 1);
    localparam logic signed [AW:0] SAT_MIN = (AW+1)'(-(2 ** (OW - 1)));

    logic [AW-1:0]       dsk_psum [NUM_COLS];
    logic [NUM_COLS-1:0] dsk_valid;
    logic                all_valid;
    logic                any_valid;
    logic                push;
    logic                pop;
    logic [VW-1:0]       rq_vec;

    logic [VW-1:0]        mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]       count_q, count_d;
    logic [CNT_WIDTH-1:0] row_cnt_q, row_cnt_d;
    logic                 frame_done_q, frame_done_d;
    logic                 skew_q, skew_d;

    // Enable is a function of registered occupancy only, so a consumer stall
    // can never combinationally reach back into the array.
    assign array_enable = ext_enable & ~rst & (count_q < (PTR_W+1)'(FIFO_DEPTH));

    // Column c is delayed by NUM_COLS-1-c stages so all lanes line up with the last column.
    for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
        localparam int D = NUM_COLS - 1 - c;
        if (D == 0) begin : g_direct
            assign dsk_psum[c]  = col_psum_in[c*AW +: AW];
            assign dsk_valid[c] = col_valid_in[c];
        end else begin : g_dly
            logic [AW-1:0] psum_q [D];
            logic [D-1:0]  valid_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < D; i++) psum_q[i] <= '0;
                    valid_q <= '0;
                end else if (array_enable) begin
                    psum_q[0]  <= col_psum_in[c*AW +: AW];
                    valid_q[0] <= col_valid_in[c];
                    for (int i = 1; i < D; i++) begin
                        psum_q[i]  <= psum_q[i-1];
                        valid_q[i] <= valid_q[i-1];
                    end
                end
            end

            assign dsk_psum[c]  = psum_q[D-1];
            assign dsk_valid[c] = valid_q[D-1];
        end
    end

    assign all_valid = &dsk_valid;
    assign any_valid = |dsk_valid;
    assign push      = array_enable & all_valid;
    assign out_valid = (count_q != '0);
    assign pop       = out_valid & out_ready;

    // One extra bit of headroom keeps the rounding add from wrapping.
    function automatic logic [OW-1:0] requant(input logic [AW-1:0] psum,
                                              input logic [4:0]    sh,
                                              input logic          relu);
        logic signed [AW:0] x;
        logic signed [AW:0] half;
        x    = signed'({psum[AW-1], psum});
        half = '0;
        if (sh != 5'd0) begin
            half = signed'((AW+1)'(1) << (sh - 5'd1));
            x    = (x + half) >>> sh;
        end
        if (relu && x[AW]) x = '0;
        if (x > SAT_MAX) return SAT_MAX[OW-1:0];
        if (x < SAT_MIN) return SAT_MIN[OW-1:0];
        return x[OW-1:0];
    endfunction

    always_comb begin
        rq_vec = '0;
        for (int c = 0; c < NUM_COLS; c++) begin
            rq_vec[c*OW +: OW] = requant(dsk_psum[c], shift_amt, relu_en);
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // A partial set of deskewed valids means the upstream skew is broken; the vector is dropped.
    always_comb begin
        skew_d       = skew_q;
        row_cnt_d    = row_cnt_q;
        frame_done_d = 1'b0;
        if (array_enable && any_valid && !all_valid) skew_d = 1'b1;
        if (push && (rows_expected != '0)) begin
            if ((row_cnt_q + CNT_WIDTH'(1)) >= rows_expected) begin
                row_cnt_d    = '0;
                frame_done_d = 1'b1;
            end else begin
                row_cnt_d = row_cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            row_cnt_q    <= '0;
            frame_done_q <= 1'b0;
            skew_q       <= 1'b0;
        end else begin
            if (push) mem_q[wr_ptr_q] <= rq_vec;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            row_cnt_q    <= row_cnt_d;
            frame_done_q <= frame_done_d;
            skew_q       <= skew_d;
        end
    end

    assign out_data   = mem_q[rd_ptr_q];
    assign frame_done = frame_done_q;
    assign skew_error = skew_q;

endmodule

// File: tb/tb_psum_drain_collector.sv
// Directed bench for psum_drain_collector: skewed column streams are generated from a
// vector table, expected lanes go into a scoreboard queue and are checked as they drain.
module tb_psum_drain_collector;

    localparam int NC = 4;
    localparam int AW = 24;
    localparam int OW = 8;
    localparam int FD = 4;
    localparam int CW = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             ext_enable;
    logic             array_enable;
    logic [NC*AW-1:0] col_psum_in;
    logic [NC-1:0]    col_valid_in;
    logic [4:0]       shift_amt;
    logic             relu_en;
    logic [CW-1:0]    rows_expected;
    logic [NC*OW-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             frame_done;
    logic             skew_error;

    always #5 clk = ~clk;

    psum_drain_collector #(
        .NUM_COLS(NC), .ACCUM_WIDTH(AW), .OUT_WIDTH(OW), .FIFO_DEPTH(FD), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst), .ext_enable(ext_enable), .array_enable(array_enable),
        .col_psum_in(col_psum_in), .col_valid_in(col_valid_in), .shift_amt(shift_amt),
        .relu_en(relu_en), .rows_expected(rows_expected), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .frame_done(frame_done),
        .skew_error(skew_error)
    );

    int n_pass  = 0;
    int n_total = 0;

    logic [NC*OW-1:0] sb_q[$];
    int st      = 0;
    int nv      = 0;
    int fcnt    = 0;
    int fd_seen = 0;
    int vps    [64][NC];
    int vstart [64];
    bit vlate  [64][NC];
    bit vgood  [64];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Round-half-up division by 2^sh, written as floor division on integers.
    function automatic int rq_model(input int p, input int sh, input bit relu);
        longint y, d, q;
        if (sh == 0) q = p;
        else begin
            d = longint'(1) << sh;
            y = longint'(p) + d / 2;
            if (y >= 0) q = y / d;
            else        q = -((-y + d - 1) / d);
        end
        if (relu && q < 0) q = 0;
        if (q > (1 << (OW - 1)) - 1) q = (1 << (OW - 1)) - 1;
        if (q < -(1 << (OW - 1)))    q = -(1 << (OW - 1));
        return int'(q);
    endfunction

    function automatic logic [NC*OW-1:0] exp_vec(input int v);
        logic [NC*OW-1:0] e;
        int r;
        e = '0;
        for (int c = 0; c < NC; c++) begin
            r = rq_model(vps[v][c], int'(shift_amt), relu_en);
            e[c*OW +: OW] = OW'(r);
        end
        return e;
    endfunction

    task automatic add_vec(input int p0, input int p1, input int p2, input int p3,
                           input int off, input int late_col);
        vps[nv][0] = p0; vps[nv][1] = p1; vps[nv][2] = p2; vps[nv][3] = p3;
        vstart[nv] = st + off;
        for (int c = 0; c < NC; c++) vlate[nv][c] = (c == late_col);
        vgood[nv] = (late_col < 0);
        nv++;
    endtask

    function automatic bit pending();
        for (int v = 0; v < nv; v++) if (vstart[v] + NC >= st) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drive_cols();
        col_valid_in = '0;
        col_psum_in  = '0;
        for (int v = 0; v < nv; v++) begin
            for (int c = 0; c < NC; c++) begin
                if (st == vstart[v] + c + int'(vlate[v][c])) begin
                    col_valid_in[c]         = 1'b1;
                    col_psum_in[c*AW +: AW] = AW'(vps[v][c]);
                end
            end
        end
    endtask

    // One clock: drive this stream step at the negedge, model writes/reads, step to next negedge.
    task automatic tick();
        bit               en;
        bit               fd_next;
        logic [NC*OW-1:0] e;
        drive_cols();
        en      = array_enable;
        fd_next = 1'b0;
        if (en) begin
            for (int v = 0; v < nv; v++) begin
                if (vgood[v] && st == vstart[v] + NC - 1) begin
                    sb_q.push_back(exp_vec(v));
                    if (rows_expected != '0) begin
                        fcnt++;
                        if (fcnt == int'(rows_expected)) begin
                            fcnt    = 0;
                            fd_next = 1'b1;
                        end
                    end
                end
            end
        end
        if (out_valid) begin
            if (out_ready) begin
                n_total++;
                assert (sb_q.size() > 0) n_pass++;
                else $error("FAIL sb_underflow: observed=%0h expected=none", out_data);
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    chk("out_data", out_data, e);
                end
            end else if (sb_q.size() > 0) begin
                chk("held_data", out_data, sb_q[0]);
            end
        end
        @(negedge clk);
        if (en) st++;
        if (frame_done) fd_seen++;
        chk("frame_done", frame_done, fd_next);
    endtask

    task automatic drain(input int limit);
        int k;
        k = 0;
        while ((sb_q.size() > 0 || out_valid || pending()) && k < limit) begin
            tick();
            k++;
        end
        n_total++;
        assert (k < limit) n_pass++;
        else $error("FAIL drain_timeout: observed=%0d cycles expected<%0d", k, limit);
    endtask

    initial begin
        rst = 1'b1; ext_enable = 1'b0; col_psum_in = '0; col_valid_in = '0;
        shift_amt = 5'd0; relu_en = 1'b0; rows_expected = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_array_enable", array_enable, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_skew_error", skew_error, 0);
        rst = 1'b0; ext_enable = 1'b1;
        @(negedge clk);
        chk("idle_enable", array_enable, 1);

        // skewed stream, single vector, latency
        add_vec(10, 11, 12, 13, 0, -1);
        repeat (3) tick();
        chk("lat_early", out_valid, 0);
        tick();
        chk("lat_one", out_valid, 1);
        chk("t1_data", out_data, {8'd13, 8'd12, 8'd11, 8'd10});
        chk("t1_skew", skew_error, 0);
        out_ready = 1'b1;
        drain(50);

        // rounding and saturation, then with ReLU
        shift_amt = 5'd4; out_ready = 1'b0;
        add_vec(24, -24, 40000, -40000, 0, -1);
        repeat (4) tick();
        chk("rnd_data", out_data, {8'h80, 8'h7F, 8'hFF, 8'h02});
        out_ready = 1'b1;
        drain(50);
        relu_en = 1'b1; out_ready = 1'b0;
        add_vec(24, -24, 40000, -40000, 0, -1);
        repeat (4) tick();
        chk("relu_data", out_data, {8'h00, 8'h7F, 8'h00, 8'h02});
        out_ready = 1'b1;
        drain(50);

        // backpressure: six vectors into a four-entry FIFO
        shift_amt = 5'd1; relu_en = 1'b0; out_ready = 1'b0;
        for (int v = 0; v < 6; v++) add_vec(v*37 - 100, -v*53 + 7, v*1000 - 2501, -(v*9) - 3, v, -1);
        repeat (12) tick();
        chk("bp_full_enable", array_enable, 0);
        chk("bp_full_valid", out_valid, 1);
        out_ready = 1'b1;
        tick();
        chk("bp_enable_rises", array_enable, 1);
        drain(100);

        // misalignment: column 2 one cycle late
        shift_amt = 5'd0;
        chk("skew_before", skew_error, 0);
        add_vec(1, 2, 3, 4, 0, 2);
        add_vec(5, 6, 7, 8, 3, -1);
        drain(50);
        chk("skew_set", skew_error, 1);
        add_vec(9, 10, 11, 12, 0, -1);
        drain(50);
        chk("skew_sticky", skew_error, 1);

        // frame counting
        rows_expected = 16'd3; fd_seen = 0;
        for (int v = 0; v < 7; v++) add_vec(v, v + 20, -v, 100 - v, v, -1);
        drain(100);
        chk("frame_pulses", fd_seen, 2);
        rows_expected = '0;

        // reset with two vectors queued and one inside the deskew lines
        out_ready = 1'b0;
        add_vec(31, 32, 33, 34, 0, -1);
        add_vec(41, 42, 43, 44, 1, -1);
        add_vec(51, 52, 53, 54, 4, -1);
        repeat (6) tick();
        chk("pre_rst_valid", out_valid, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_enable", array_enable, 0);
        chk("mid_rst_data", out_data, 0);
        chk("mid_rst_skew", skew_error, 0);
        nv = 0; fcnt = 0; sb_q.delete();
        col_valid_in = '0; col_psum_in = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        add_vec(100, -100, 50, -50, 0, -1);
        out_ready = 1'b1;
        drain(50);
        repeat (8) tick();
        chk("post_rst_skew", skew_error, 0);
        chk("post_rst_empty", out_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
